dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Two-master arbiter for the single data memory (DM). Master 0 is the CPU data port
//  (ALU address, DMWr/DMRe codes). Master 1 is the debug/loader port.
//  It grants DM to one master at a time, using round-robin with an optional bounded lock.
//  It muxes the owner's command onto DM and returns registered read data.
//  It also raises a stall to the CPU while master 0 waits.
// PARAMETERS
//  AW        8   DM byte-address width; matches the ALUResult[7:0] address.
//  DW        32  Data width.
//  MAX_HOLD  4   Max consecutive owned cycles under lock while the other master waits (>=1).
// PORTS
//  clk         in   1   Clock; rising edge.
//  rst         in   1   Reset; asynchronous, active-high.
//  m0_req      in   1   Master 0 requests DM.
//  m0_lock     in   1   Master 0 asks to keep ownership (burst).
//  m0_wr       in   2   Master 0 DMWr code (0 = no write).
//  m0_re       in   3   Master 0 DMRe code (0 = no read).
//  m0_addr     in   AW  Master 0 address.
//  m0_wdata    in   DW  Master 0 write data.
//  m0_gnt      out  1   Master 0 owns DM this cycle.
//  m0_stall    out  1   m0_req & ~m0_gnt (combinational CPU stall).
//  m0_rvalid   out  1   Master 0 read data valid.
//  m0_rdata    out  DW  Master 0 read data (registered).
//  m1_*        ---  --  Same set as m0_* for master 1, without m1_stall.
//  dm_wr       out  2   To DM DMWr.
//  dm_re       out  3   To DM DMRe.
//  dm_addr     out  AW  To DM Addr.
//  dm_wdata    out  DW  To DM DataIn.
//  dm_rdata    in   DW  From DM DataOut (combinational read).
// BEHAVIOUR
//  Reset values (rst=1, asynchronous):
//   - state=IDLE, last=1, so master 0 wins the first tie; hold_cnt=0.
//   - All gnt, rvalid and rdata = 0.
//   - dm_wr=0, dm_re=0, dm_addr=0, dm_wdata=0.
//  States are IDLE, OWN0 and OWN1. gntX = (state==OWNx), decoded from registered state.
//  Access rule: in OWNx with reqX=1, dm_* = mX_*. In every other case, dm_* = 0.
//   Masters hold all command inputs stable while req=1 and gnt=0.
//  IDLE transitions:
//   - Only reqX -> OWNx.
//   - Both requesting -> OWN of the master != last.
//   - Neither -> stay IDLE.
//  OWNx transitions (Y = other master), evaluated each edge:
//   - ~reqX: reqY -> OWNy, else IDLE.
//   - reqX & reqY & (~lockX | hold_cnt==MAX_HOLD-1) -> OWNy.
//   - Otherwise stay in OWNx.
//   - OWNx->OWNy is direct, with no IDLE bubble.
//  last <= X whenever the state leaves OWNx.
//  hold_cnt: cleared on entering any OWN state; +1 per cycle staying in OWN;
//   saturates at MAX_HOLD-1.
//  Read return: an access with re!=0 in cycle n gives mX_rvalid=1 and
//   mX_rdata=dm_rdata(n) in cycle n+1. rvalid is a 1-cycle pulse.
//   rdata holds its value until the next read.
//  Write: commits at the edge ending the granted cycle (DM-clocked). No response signal.
//  Latency: req rising in IDLE at cycle n -> gnt at n+1 -> rvalid at n+2.
//   With back-to-back requests while owning, throughput is 1 access per cycle.
//  Contention without lock alternates the grant every cycle: 0,1,0,1...
//  A req dropped during the granted cycle still gets that cycle's access if req was 1.
//   Once req is 0, no access occurs.
//  Reset mid-transfer: state goes to IDLE immediately, so dm_wr/dm_re are forced to 0
//   and no write commits. A pending rvalid is squashed.
//  The lock is ignored when the other master is not requesting; ownership simply persists.
// TESTING
//  1 Reset, then m0 read addr 0x10 (DM[0x10]=0xDEADBEEF) at cycle 1:
//    -> m0_gnt @2, m0_rvalid @3, m0_rdata=0xDEADBEEF, m0_stall=1 @1 only.
//  2 m0 and m1 both req from IDLE, no lock, 4 cycles:
//    -> gnt order 0,1,0,1, and each master's rvalid follows its grant by 1.
//  3 m1 lock=1 with m0 requesting, MAX_HOLD=4:
//    -> m1 owns exactly 4 cycles, then m0 is granted; m0_stall=1 during m1 ownership.
//  4 m0 write wr=1 data 0x12345678 to 0x20, then m1 reads 0x20:
//    -> m1_rdata=0x12345678. Also check dm_wr=0 in every cycle with no owner.
//  5 Assert rst mid-cycle while m1 owns with wr=1:
//    -> dm_wr=0 immediately, target word unchanged, all gnt/rvalid=0.
//    -> After release, m0 wins the tie.
//  6 Owner drops req while the other idle:
//    -> state IDLE next cycle; gnt=0; dm_* all zero.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Two-master data-memory arbiter. Round-robin with bounded lock,
//               command mux onto DM, registered per-master read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [1:0]    m0_wr,
    input  logic [2:0]    m0_re,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_stall,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [1:0]    m1_wr,
    input  logic [2:0]    m1_re,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    dm_wr,
    output logic [2:0]    dm_re,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    input  logic [DW-1:0] dm_rdata
);

    localparam int              HW         = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0]   c_hold_max = HW'(MAX_HOLD - 1);
    localparam logic [1:0]      c_idle     = 2'd0;
    localparam logic [1:0]      c_own0     = 2'd1;
    localparam logic [1:0]      c_own1     = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_last;
    logic [HW-1:0] r_hold_cnt;
    logic          w_hold_done;
    logic          w_acc0;
    logic          w_acc1;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    assign w_hold_done = (r_hold_cnt == c_hold_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_last     <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_hold_cnt <= '0;
                if (r_state == c_own0)
                    r_last <= 1'b0;
                else if (r_state == c_own1)
                    r_last <= 1'b1;
            end else if (r_state != c_idle && !w_hold_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    // A lock only delays handover while the other master waits, and only up to MAX_HOLD cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: begin
                if (m0_req && m1_req)
                    w_next = r_last ? c_own0 : c_own1;
                else if (m0_req)
                    w_next = c_own0;
                else if (m1_req)
                    w_next = c_own1;
            end
            c_own0: begin
                if (!m0_req)
                    w_next = m1_req ? c_own1 : c_idle;
                else if (m1_req && (!m0_lock || w_hold_done))
                    w_next = c_own1;
            end
            c_own1: begin
                if (!m1_req)
                    w_next = m0_req ? c_own0 : c_idle;
                else if (m0_req && (!m1_lock || w_hold_done))
                    w_next = c_own0;
            end
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        m0_gnt   = (r_state == c_own0);
        m1_gnt   = (r_state == c_own1);
        m0_stall = m0_req & ~m0_gnt;
        w_acc0   = m0_gnt & m0_req;
        w_acc1   = m1_gnt & m1_req;
        dm_wr    = '0;
        dm_re    = '0;
        dm_addr  = '0;
        dm_wdata = '0;
        if (w_acc0) begin
            dm_wr    = m0_wr;
            dm_re    = m0_re;
            dm_addr  = m0_addr;
            dm_wdata = m0_wdata;
        end else if (w_acc1) begin
            dm_wr    = m1_wr;
            dm_re    = m1_re;
            dm_addr  = m1_addr;
            dm_wdata = m1_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_acc0 && (m0_re != 3'd0);
            r_m1_rvalid <= w_acc1 && (m1_re != 3'd0);
            if (w_acc0 && (m0_re != 3'd0))
                r_m0_rdata <= dm_rdata;
            if (w_acc1 && (m1_re != 3'd0))
                r_m1_rdata <= dm_rdata;
        end
    end

    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Directed, table-driven bench for dm_arbiter with a DM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [1:0]  m0_wr, m1_wr, dm_wr;
    logic [2:0]  m0_re, m1_re, dm_re;
    logic [7:0]  m0_addr, m1_addr, dm_addr;
    logic [31:0] m0_wdata, m1_wdata, dm_wdata, dm_rdata;
    logic        m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;

    logic [31:0] mem [0:255];
    int          n_tests = 0;
    int          n_fail  = 0;

    dm_arbiter #(.AW(8), .DW(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_wr(m0_wr), .m0_re(m0_re),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_stall(m0_stall),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_wr(m1_wr), .m1_re(m1_re),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .dm_wr(dm_wr), .dm_re(dm_re), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-per-address DM: combinational read, write at the clock edge.
    assign dm_rdata = mem[dm_addr];
    always @(posedge clk) if (dm_wr != 2'd0) mem[dm_addr] <= dm_wdata;

    typedef struct {
        logic        rst;
        logic        r0, l0;  logic [1:0] w0; logic [2:0] e0; logic [7:0] a0; logic [31:0] d0;
        logic        r1, l1;  logic [1:0] w1; logic [2:0] e1; logic [7:0] a1; logic [31:0] d1;
        logic        g0, g1, st, rv0, rv1;
        logic [31:0] rd0, rd1;
        logic [1:0]  dwr; logic [2:0] dre; logic [7:0] dad; logic [31:0] dwd;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    task automatic set_in(input int i, input logic rs,
                          input logic r0, input logic l0, input logic [1:0] w0, input logic [2:0] e0,
                          input logic [7:0] a0, input logic [31:0] d0,
                          input logic r1, input logic l1, input logic [1:0] w1, input logic [2:0] e1,
                          input logic [7:0] a1, input logic [31:0] d1);
        tbl[i].rst = rs;
        tbl[i].r0 = r0; tbl[i].l0 = l0; tbl[i].w0 = w0; tbl[i].e0 = e0; tbl[i].a0 = a0; tbl[i].d0 = d0;
        tbl[i].r1 = r1; tbl[i].l1 = l1; tbl[i].w1 = w1; tbl[i].e1 = e1; tbl[i].a1 = a1; tbl[i].d1 = d1;
    endtask

    task automatic set_ex(input int i, input logic g0, input logic g1, input logic st,
                          input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1,
                          input logic [1:0] dwr, input logic [2:0] dre, input logic [7:0] dad,
                          input logic [31:0] dwd);
        tbl[i].g0 = g0; tbl[i].g1 = g1; tbl[i].st = st; tbl[i].rv0 = rv0; tbl[i].rv1 = rv1;
        tbl[i].rd0 = rd0; tbl[i].rd1 = rd1;
        tbl[i].dwr = dwr; tbl[i].dre = dre; tbl[i].dad = dad; tbl[i].dwd = dwd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        m0_req = v.r0; m0_lock = v.l0; m0_wr = v.w0; m0_re = v.e0; m0_addr = v.a0; m0_wdata = v.d0;
        m1_req = v.r1; m1_lock = v.l1; m1_wr = v.w1; m1_re = v.e1; m1_addr = v.a1; m1_wdata = v.d1;
    endtask

    localparam logic [31:0] A = 32'hDEADBEEF;
    localparam logic [31:0] B = 32'h11111111;
    localparam logic [31:0] C = 32'h12345678;
    localparam logic [31:0] D = 32'hCAFEF00D;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = A;
        mem[8'h11] = B;
        rst = 1'b1;
        m0_req = 0; m0_lock = 0; m0_wr = 0; m0_re = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_lock = 0; m1_wr = 0; m1_re = 0; m1_addr = 0; m1_wdata = 0;

        //            rst  r0 l0 w0 e0 a0     d0   r1 l1 w1 e1 a1     d1
        set_in( 0, 1,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in( 1, 0,   1, 0, 0, 1, 8'h10, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in( 2, 0,   1, 0, 0, 1, 8'h10, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in( 3, 0,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in( 4, 0,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in( 5, 1,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        for (int i = 6; i <= 10; i++)
            set_in(i, 0, 1, 0, 0, 1, 8'h10, 0,  1, 0, 0, 1, 8'h11, 0);
        for (int i = 11; i <= 15; i++)
            set_in(i, 0, 1, 0, 0, 1, 8'h10, 0,  1, 1, 0, 1, 8'h11, 0);
        set_in(16, 0,   1, 0, 1, 0, 8'h20, C,   0, 0, 0, 0, 8'h00, 0);
        set_in(17, 0,   0, 0, 0, 0, 8'h00, 0,   1, 0, 0, 1, 8'h20, 0);
        set_in(18, 0,   0, 0, 0, 0, 8'h00, 0,   1, 0, 0, 1, 8'h20, 0);
        set_in(19, 0,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in(20, 0,   0, 0, 0, 0, 8'h00, 0,   0, 0, 0, 0, 8'h00, 0);
        set_in(21, 0,   0, 0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 8'h30, D);
        set_in(22, 0,   0, 0, 0, 0, 8'h00, 0,   1, 0, 1, 1, 8'h30, D);

        //          g0 g1 st rv0 rv1 rd0 rd1 dwr dre dad    dwd
        set_ex( 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h00, 0);
        set_ex( 1,  0, 0, 1, 0,  0,  0,  0,  0,  0,  8'h00, 0);
        set_ex( 2,  1, 0, 0, 0,  0,  0,  0,  0,  1,  8'h10, 0);
        set_ex( 3,  1, 0, 0, 1,  0,  A,  0,  0,  0,  8'h00, 0);
        set_ex( 4,  0, 0, 0, 0,  0,  A,  0,  0,  0,  8'h00, 0);
        set_ex( 5,  0, 0, 0, 0,  0,  0,  0,  0,  0,  8'h00, 0);
        set_ex( 6,  0, 0, 1, 0,  0,  0,  0,  0,  0,  8'h00, 0);
        set_ex( 7,  1, 0, 0, 0,  0,  0,  0,  0,  1,  8'h10, 0);
        set_ex( 8,  0, 1, 1, 1,  0,  A,  0,  0,  1,  8'h11, 0);
        set_ex( 9,  1, 0, 0, 0,  1,  A,  B,  0,  1,  8'h10, 0);
        set_ex(10,  0, 1, 1, 1,  0,  A,  B,  0,  1,  8'h11, 0);
        set_ex(11,  1, 0, 0, 0,  1,  A,  B,  0,  1,  8'h10, 0);
        set_ex(12,  0, 1, 1, 1,  0,  A,  B,  0,  1,  8'h11, 0);
        set_ex(13,  0, 1, 1, 0,  1,  A,  B,  0,  1,  8'h11, 0);
        set_ex(14,  0, 1, 1, 0,  1,  A,  B,  0,  1,  8'h11, 0);
        set_ex(15,  0, 1, 1, 0,  1,  A,  B,  0,  1,  8'h11, 0);
        set_ex(16,  1, 0, 0, 0,  1,  A,  B,  1,  0,  8'h20, C);
        set_ex(17,  1, 0, 0, 0,  0,  A,  B,  0,  0,  8'h00, 0);
        set_ex(18,  0, 1, 0, 0,  0,  A,  B,  0,  1,  8'h20, 0);
        set_ex(19,  0, 1, 0, 0,  1,  A,  C,  0,  0,  8'h00, 0);
        set_ex(20,  0, 0, 0, 0,  0,  A,  C,  0,  0,  8'h00, 0);
        set_ex(21,  0, 0, 0, 0,  0,  A,  C,  0,  0,  8'h00, 0);
        set_ex(22,  0, 1, 0, 0,  0,  A,  C,  1,  1,  8'h30, D);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("r%0d m0_gnt", i),    {31'b0, m0_gnt},    {31'b0, tbl[i].g0});
            chk($sformatf("r%0d m1_gnt", i),    {31'b0, m1_gnt},    {31'b0, tbl[i].g1});
            chk($sformatf("r%0d m0_stall", i),  {31'b0, m0_stall},  {31'b0, tbl[i].st});
            chk($sformatf("r%0d m0_rvalid", i), {31'b0, m0_rvalid}, {31'b0, tbl[i].rv0});
            chk($sformatf("r%0d m1_rvalid", i), {31'b0, m1_rvalid}, {31'b0, tbl[i].rv1});
            chk($sformatf("r%0d m0_rdata", i),  m0_rdata,           tbl[i].rd0);
            chk($sformatf("r%0d m1_rdata", i),  m1_rdata,           tbl[i].rd1);
            chk($sformatf("r%0d dm_wr", i),     {30'b0, dm_wr},     {30'b0, tbl[i].dwr});
            chk($sformatf("r%0d dm_re", i),     {29'b0, dm_re},     {29'b0, tbl[i].dre});
            chk($sformatf("r%0d dm_addr", i),   {24'b0, dm_addr},   {24'b0, tbl[i].dad});
            chk($sformatf("r%0d dm_wdata", i),  dm_wdata,           tbl[i].dwd);
        end

        // Reset asserted mid-cycle while m1 owns with a write+read in flight.
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid dm_wr",     {30'b0, dm_wr},     32'd0);
        chk("rstmid dm_re",     {29'b0, dm_re},     32'd0);
        chk("rstmid m0_gnt",    {31'b0, m0_gnt},    32'd0);
        chk("rstmid m1_gnt",    {31'b0, m1_gnt},    32'd0);
        chk("rstmid m0_rvalid", {31'b0, m0_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("rstmid mem30",     mem[8'h30],         32'd0);
        chk("rstmid m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        chk("rstmid m1_rdata",  m1_rdata,           32'd0);

        // After release, a tie goes to master 0.
        @(negedge clk);
        rst = 1'b0;
        m0_req = 1; m0_lock = 0; m0_wr = 0; m0_re = 1; m0_addr = 8'h10; m0_wdata = 0;
        m1_req = 1; m1_lock = 0; m1_wr = 0; m1_re = 1; m1_addr = 8'h11; m1_wdata = 0;
        #1;
        chk("tie idle m0_gnt",  {31'b0, m0_gnt},   32'd0);
        chk("tie idle m1_gnt",  {31'b0, m1_gnt},   32'd0);
        chk("tie idle stall",   {31'b0, m0_stall}, 32'd1);
        @(negedge clk);
        #1;
        chk("tie m0_gnt",       {31'b0, m0_gnt},   32'd1);
        chk("tie m1_gnt",       {31'b0, m1_gnt},   32'd0);
        chk("tie dm_addr",      {24'b0, dm_addr},  32'h10);
        @(negedge clk);
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
